// File: rtl/ps2_zx_keymatrix.sv
// PS/2 keyboard to ZX Spectrum 8x5 key matrix, answering the ULA port #FE read on kd.
// Synchronizes and filters the PS/2 lines, receives frames, and decodes make/break codes.
module ps2_zx_keymatrix #(
  parameter int unsigned TIMEOUT = 1792
) (
  input  logic       clk14_i,
  input  logic       rst_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  input  logic [7:0] addr_hi_i,
  output logic [4:0] kd_o,
  output logic       frame_err_o
);

  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

  // Synchronizers and clock filter
  logic [1:0] clk_sync_q, dat_sync_q;
  logic [2:0] filt_cnt_q, filt_cnt_d;
  logic       filt_q, filt_d;
  logic       fall;

  always_ff @(posedge clk14_i) begin
    if (!rst_n_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_cnt_q <= '0;
      filt_q     <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      filt_cnt_q <= filt_cnt_d;
      filt_q     <= filt_d;
    end
  end

  // The filtered level flips on the 8th consecutive sample that disagrees with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == 3'd7) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 3'd1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  // Frame receiver
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     shift_q, shift_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]     byte_q, byte_d;
  logic           byte_valid_q, byte_valid_d;
  logic           frame_err_q, frame_err_d;

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        // shift_q[0] is the start bit, [8:1] data, [9] parity; the live sample is the stop bit.
        if (!shift_q[0] && dat_sync_q[1] && (^shift_q[9:1])) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {dat_sync_q[1], shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
    end
  end

  always_ff @(posedge clk14_i) begin
    if (!rst_n_i) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign frame_err_o = frame_err_q;

  // Scancode lookup: {hit, row, column}
  function automatic logic [6:0] map_code(input logic [7:0] code);
    case (code)
      8'h12: map_code = {1'b1, 3'd0, 3'd0};
      8'h1A: map_code = {1'b1, 3'd0, 3'd1};
      8'h22: map_code = {1'b1, 3'd0, 3'd2};
      8'h21: map_code = {1'b1, 3'd0, 3'd3};
      8'h2A: map_code = {1'b1, 3'd0, 3'd4};
      8'h1C: map_code = {1'b1, 3'd1, 3'd0};
      8'h1B: map_code = {1'b1, 3'd1, 3'd1};
      8'h23: map_code = {1'b1, 3'd1, 3'd2};
      8'h2B: map_code = {1'b1, 3'd1, 3'd3};
      8'h34: map_code = {1'b1, 3'd1, 3'd4};
      8'h15: map_code = {1'b1, 3'd2, 3'd0};
      8'h1D: map_code = {1'b1, 3'd2, 3'd1};
      8'h24: map_code = {1'b1, 3'd2, 3'd2};
      8'h2D: map_code = {1'b1, 3'd2, 3'd3};
      8'h2C: map_code = {1'b1, 3'd2, 3'd4};
      8'h16: map_code = {1'b1, 3'd3, 3'd0};
      8'h1E: map_code = {1'b1, 3'd3, 3'd1};
      8'h26: map_code = {1'b1, 3'd3, 3'd2};
      8'h25: map_code = {1'b1, 3'd3, 3'd3};
      8'h2E: map_code = {1'b1, 3'd3, 3'd4};
      8'h45: map_code = {1'b1, 3'd4, 3'd0};
      8'h46: map_code = {1'b1, 3'd4, 3'd1};
      8'h3E: map_code = {1'b1, 3'd4, 3'd2};
      8'h3D: map_code = {1'b1, 3'd4, 3'd3};
      8'h36: map_code = {1'b1, 3'd4, 3'd4};
      8'h4D: map_code = {1'b1, 3'd5, 3'd0};
      8'h44: map_code = {1'b1, 3'd5, 3'd1};
      8'h43: map_code = {1'b1, 3'd5, 3'd2};
      8'h3C: map_code = {1'b1, 3'd5, 3'd3};
      8'h35: map_code = {1'b1, 3'd5, 3'd4};
      8'h5A: map_code = {1'b1, 3'd6, 3'd0};
      8'h4B: map_code = {1'b1, 3'd6, 3'd1};
      8'h42: map_code = {1'b1, 3'd6, 3'd2};
      8'h3B: map_code = {1'b1, 3'd6, 3'd3};
      8'h33: map_code = {1'b1, 3'd6, 3'd4};
      8'h29: map_code = {1'b1, 3'd7, 3'd0};
      8'h59: map_code = {1'b1, 3'd7, 3'd1};
      8'h14: map_code = {1'b1, 3'd7, 3'd1};
      8'h3A: map_code = {1'b1, 3'd7, 3'd2};
      8'h31: map_code = {1'b1, 3'd7, 3'd3};
      8'h32: map_code = {1'b1, 3'd7, 3'd4};
      default: map_code = '0;
    endcase
  endfunction

  function automatic logic [6:0] map_ext(input logic [7:0] code);
    case (code)
      8'h14: map_ext = {1'b1, 3'd7, 3'd1};
      8'h5A: map_ext = {1'b1, 3'd6, 3'd0};
      default: map_ext = '0;
    endcase
  endfunction

  logic [6:0] norm_map, ext_map;
  assign norm_map = map_code(byte_q);
  assign ext_map  = map_ext(byte_q);

  // Decoder FSM and key matrix
  state_e          state_q;
  logic [2:0]      skip_q;
  logic [7:0][4:0] key_q;

  always_ff @(posedge clk14_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      skip_q  <= '0;
      key_q   <= '0;
    end else if (byte_valid_q) begin
      unique case (state_q)
        StIdle: begin
          if (byte_q == 8'hE0) begin
            state_q <= StExt;
          end else if (byte_q == 8'hF0) begin
            state_q <= StBrk;
          end else if (byte_q == 8'hE1) begin
            state_q <= StSkip;
            skip_q  <= 3'd7;
          end else if (byte_q == 8'hAA || byte_q == 8'h00 || byte_q == 8'hFF) begin
            key_q <= '0;
          end else if (norm_map[6]) begin
            key_q[norm_map[5:3]][norm_map[2:0]] <= 1'b1;
          end
        end
        StExt: begin
          if (byte_q == 8'hF0) begin
            state_q <= StExtBrk;
          end else begin
            if (ext_map[6]) key_q[ext_map[5:3]][ext_map[2:0]] <= 1'b1;
            state_q <= StIdle;
          end
        end
        StBrk: begin
          if (norm_map[6]) key_q[norm_map[5:3]][norm_map[2:0]] <= 1'b0;
          state_q <= StIdle;
        end
        StExtBrk: begin
          if (ext_map[6]) key_q[ext_map[5:3]][ext_map[2:0]] <= 1'b0;
          state_q <= StIdle;
        end
        StSkip: begin
          skip_q <= skip_q - 3'd1;
          if (skip_q == 3'd1) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Column output: OR of every selected half-row, inverted and registered
  logic [4:0] sel_cols;
  logic [4:0] kd_q;

  always_comb begin
    sel_cols = '0;
    for (int r = 0; r < 8; r++) begin
      if (!addr_hi_i[r]) sel_cols = sel_cols | key_q[r];
    end
  end

  always_ff @(posedge clk14_i) begin
    if (!rst_n_i) begin
      kd_q <= 5'b11111;
    end else begin
      kd_q <= ~sel_cols;
    end
  end

  assign kd_o = kd_q;

endmodule

// File: tb/tb_ps2_zx_keymatrix.sv
// Bench for ps2_zx_keymatrix: directed steps plus random key traffic against a matrix model.
module tb_ps2_zx_keymatrix;

  localparam int Half = 16;

  logic       clk14 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] addr_hi = 8'h00;
  logic [4:0] kd;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cycles = 0;

  ps2_zx_keymatrix #(.TIMEOUT(1792)) dut (
    .clk14_i    (clk14),
    .rst_n_i    (rst_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_dat_i  (ps2_dat),
    .addr_hi_i  (addr_hi),
    .kd_o       (kd),
    .frame_err_o(frame_err)
  );

  always #5 clk14 = ~clk14;

  always @(negedge clk14) if (frame_err === 1'b1) err_cycles++;

  // Key table in row-major order (index = row*5 + column); entry 40 is the second SS code.
  logic [7:0] tab [41] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h59, 8'h3A, 8'h31, 8'h32,
    8'h14
  };

  // Reference model: pressed keys plus pending prefix flags
  bit mkey [40];
  bit m_ext, m_brk;
  int m_skip;

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 41; i++) if (tab[i] == b) return (i == 40) ? 36 : i;
    return -1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 40; i++) mkey[i] = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int idx;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0 && !m_ext && !m_brk) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1'b1;
    end else if (b == 8'hE1 && !m_ext && !m_brk) begin
      m_skip = 7;
    end else if (!m_ext && !m_brk && (b == 8'hAA || b == 8'h00 || b == 8'hFF)) begin
      model_clear();
    end else begin
      if (m_ext) idx = (b == 8'h14) ? 36 : (b == 8'h5A) ? 30 : -1;
      else       idx = lookup(b);
      if (idx >= 0) mkey[idx] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic logic [4:0] exp_kd(input logic [7:0] a);
    logic [4:0] s;
    s = '0;
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 5; n++)
        if (!a[r] && mkey[r*5+n]) s[n] = 1'b1;
    return ~s;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk14);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      cyc(Half);
      ps2_clk = 1'b0;
      cyc(Half);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    cyc(Half);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(f, 11);
    cyc(4);
    if (!bad_par) model_byte(b);
  endtask

  task automatic check_kd(input logic [7:0] a, input string tag);
    logic [4:0] e;
    addr_hi = a;
    cyc(2);
    e = exp_kd(a);
    n_cmp++;
    assert (kd === e) else begin
      n_bad++;
      $error("FAIL %s: addr_hi=%h kd=%h expected %h", tag, a, kd, e);
    end
  endtask

  task automatic check_val(input int got, input int want, input string tag);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  initial begin
    int err_base;
    int k;
    int kind;
    logic [7:0] code;

    model_clear();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_skip = 0;

    // Reset
    cyc(4);
    check_kd(8'h00, "reset_kd");
    check_val(int'(frame_err), 0, "reset_frame_err");
    rst_n = 1'b1;
    cyc(2);

    // Press and release
    addr_hi = 8'hFD;
    send_byte(8'h1C, 1'b0);
    check_kd(8'hFD, "press_A");
    n_cmp++;
    assert (kd === 5'h1E) else begin
      n_bad++;
      $error("FAIL press_A_const: kd=%h expected 1e", kd);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_kd(8'hFD, "release_A");

    // Row combining
    send_byte(8'h12, 1'b0);
    send_byte(8'h29, 1'b0);
    check_kd(8'h7F, "row7_space");
    check_kd(8'hFE, "row0_cs");
    check_kd(8'h7E, "rows_0_7");
    check_kd(8'hFF, "no_rows");

    // Extended keys
    send_byte(8'hE0, 1'b0);
    send_byte(8'h5A, 1'b0);
    check_kd(8'hBF, "ext_enter_press");
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h5A, 1'b0);
    check_kd(8'hBF, "ext_enter_release");
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check_kd(8'h00, "ext_unmapped");

    // Parity error
    err_base = err_cycles;
    send_byte(8'h1C, 1'b1);
    check_val(err_cycles - err_base, 1, "parity_err_pulse");
    check_kd(8'hFD, "parity_err_discard");
    send_byte(8'h1C, 1'b0);
    check_kd(8'hFD, "after_err_press");
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);

    // Timeout aborts a partial frame
    send_bits(11'h000, 5);
    cyc(1900);
    send_byte(8'h16, 1'b0);
    check_kd(8'hF7, "timeout_then_1");

    // Pause sequence is swallowed
    send_byte(8'hE1, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'hE1, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h77, 1'b0);
    check_kd(8'h7F, "pause_row7");
    check_kd(8'h00, "pause_all");

    // Shared SS bit: press via 59, release via E0 F0 14
    send_byte(8'h59, 1'b0);
    check_kd(8'h7F, "ss_press");
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h14, 1'b0);
    check_kd(8'h7F, "ss_ext_release");

    // AA clears the matrix
    send_byte(8'hAA, 1'b0);
    check_kd(8'h00, "aa_clear");

    // Reset mid-frame, then a normal frame
    send_byte(8'h2E, 1'b0);
    send_bits(11'h000, 4);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    model_clear();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_skip = 0;
    check_kd(8'h00, "reset_mid_clear");
    send_byte(8'h1C, 1'b0);
    check_kd(8'hFD, "reset_mid_next");

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 40);
      kind = $urandom_range(0, 3);
      code = tab[k];
      case (kind)
        0, 1: send_byte(code, 1'b0);
        2: begin
          send_byte(8'hF0, 1'b0);
          send_byte(code, 1'b0);
        end
        default: begin
          send_byte(8'hE0, 1'b0);
          if ($urandom_range(0, 1) == 1) send_byte(8'hF0, 1'b0);
          send_byte(($urandom_range(0, 1) == 1) ? 8'h14 : 8'h5A, 1'b0);
        end
      endcase
      check_kd(8'($urandom), "rand");
    end

    check_val(err_cycles, 1, "frame_err_total");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
